// File: rtl/cam_pkg.sv
// Shared definitions for the OV7670 pixel capture path.
//   PIX_W         : RGB565 pixel width
//   H/V_ACTIVE_DEF: default frame geometry (VGA)
//   CAM_BUS_W     : width of the raw camera bus {pclk, vsync, href, data[7:0]}
//   cap_state_e   : capture FSM states
package cam_pkg;
    localparam int PIX_W        = 16;
    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;
    localparam int CAM_BUS_W    = 11;

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_WAIT_FRAME = 2'd1;
    localparam logic [1:0] ST_ACTIVE     = 2'd2;

    typedef enum logic [1:0] {
        IDLE       = ST_IDLE,
        WAIT_FRAME = ST_WAIT_FRAME,
        ACTIVE     = ST_ACTIVE
    } cap_state_e;
endpackage

// File: rtl/cam_input_sync.sv
// Brings the asynchronous camera bus into the clk_i domain and derives
// edge strobes.
//   clk_i, rst_i             : system clock, async active-low reset
//   cam_*_i                  : raw camera PCLK/VSYNC/HREF/D[7:0]
//   href_o, data_o           : synchronized HREF/data, aligned with strobes
//   pclk_rise_o, vsync_rise_o, vsync_fall_o, href_fall_o : 1-cycle strobes
module cam_input_sync
    import cam_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       cam_pclk_i,
    input  logic       cam_vsync_i,
    input  logic       cam_href_i,
    input  logic [7:0] cam_data_i,
    output logic       href_o,
    output logic [7:0] data_o,
    output logic       pclk_rise_o,
    output logic       vsync_rise_o,
    output logic       vsync_fall_o,
    output logic       href_fall_o
);
    localparam int PCLK_B  = 10;
    localparam int VSYNC_B = 9;
    localparam int HREF_B  = 8;

    // The whole bus moves through one shift register so that every bit
    // sees the same number of stages.
    logic [SYNC_STAGES-1:0][CAM_BUS_W-1:0] sync_q;
    logic [CAM_BUS_W-1:0] last;
    logic [CAM_BUS_W-1:0] dly_q;
    logic pclk_rise_q, vsync_rise_q, vsync_fall_q, href_fall_q;

    assign last = sync_q[SYNC_STAGES-1];

    // Strobes are registered in the same edge that moves 'last' into dly_q,
    // so a strobe and the bus value it refers to are visible together.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sync_q       <= '0;
            dly_q        <= '0;
            pclk_rise_q  <= 1'b0;
            vsync_rise_q <= 1'b0;
            vsync_fall_q <= 1'b0;
            href_fall_q  <= 1'b0;
        end else begin
            sync_q       <= {sync_q[SYNC_STAGES-2:0],
                             {cam_pclk_i, cam_vsync_i, cam_href_i, cam_data_i}};
            dly_q        <= last;
            pclk_rise_q  <=  last[PCLK_B]  & ~dly_q[PCLK_B];
            vsync_rise_q <=  last[VSYNC_B] & ~dly_q[VSYNC_B];
            vsync_fall_q <= ~last[VSYNC_B] &  dly_q[VSYNC_B];
            href_fall_q  <= ~last[HREF_B]  &  dly_q[HREF_B];
        end
    end

    assign href_o       = dly_q[HREF_B];
    assign data_o       = dly_q[7:0];
    assign pclk_rise_o  = pclk_rise_q;
    assign vsync_rise_o = vsync_rise_q;
    assign vsync_fall_o = vsync_fall_q;
    assign href_fall_o  = href_fall_q;
endmodule

// File: rtl/cam_pixel_capture.sv
// OV7670 parallel-bus capture: assembles RGB565 pixels with x/y coordinates
// and streams them out on valid/ready, checking frame geometry.
//   clk_i, rst_i        : system clock, async active-low reset
//   setup_done_i        : camera register setup finished; 0 holds block idle
//   capture_en_i        : frame capture enable, looked at on VSYNC fall only
//   cam_*_i             : camera PCLK/VSYNC/HREF/D[7:0] (asynchronous)
//   pix_*               : pixel stream, one-deep output register
//   frame_start/done_o  : 1-cycle frame pulses
//   line_err/frame_err/overflow_o : sticky faults, cleared by err_clr_i
module cam_pixel_capture
    import cam_pkg::*;
#(
    parameter int H_ACTIVE    = H_ACTIVE_DEF,
    parameter int V_ACTIVE    = V_ACTIVE_DEF,
    parameter int X_W         = 10,
    parameter int Y_W         = 9,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             setup_done_i,
    input  logic             capture_en_i,
    input  logic             cam_pclk_i,
    input  logic             cam_vsync_i,
    input  logic             cam_href_i,
    input  logic [7:0]       cam_data_i,
    output logic             pix_valid_o,
    input  logic             pix_ready_i,
    output logic [PIX_W-1:0] pix_data_o,
    output logic [X_W-1:0]   pix_x_o,
    output logic [Y_W-1:0]   pix_y_o,
    output logic             frame_start_o,
    output logic             frame_done_o,
    output logic             line_err_o,
    output logic             frame_err_o,
    output logic             overflow_o,
    input  logic             err_clr_i
);
    localparam logic [X_W-1:0] X_EXP = X_W'(H_ACTIVE);
    localparam logic [Y_W-1:0] Y_EXP = Y_W'(V_ACTIVE);
    localparam logic [X_W-1:0] X_MAX = '1;
    localparam logic [Y_W-1:0] Y_MAX = '1;

    logic       href_s, pclk_rise, vsync_rise, vsync_fall, href_fall;
    logic [7:0] data_s;

    cam_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .cam_pclk_i   (cam_pclk_i),
        .cam_vsync_i  (cam_vsync_i),
        .cam_href_i   (cam_href_i),
        .cam_data_i   (cam_data_i),
        .href_o       (href_s),
        .data_o       (data_s),
        .pclk_rise_o  (pclk_rise),
        .vsync_rise_o (vsync_rise),
        .vsync_fall_o (vsync_fall),
        .href_fall_o  (href_fall)
    );

    cap_state_e       state_q, state_d;
    logic [X_W-1:0]   x_q, x_d, pix_x_q, pix_x_d;
    logic [Y_W-1:0]   y_q, y_d, pix_y_q, pix_y_d;
    logic             phase_q, phase_d;
    logic [7:0]       hi_q, hi_d;
    logic             pix_valid_q, pix_valid_d;
    logic [PIX_W-1:0] pix_data_q, pix_data_d;
    logic             fs_q, fs_d, fd_q, fd_d;
    logic             line_err_q, line_err_d, frame_err_q, frame_err_d;
    logic             ovf_q, ovf_d;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            phase_q     <= 1'b0;
            hi_q        <= '0;
            pix_valid_q <= 1'b0;
            pix_data_q  <= '0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
            fs_q        <= 1'b0;
            fd_q        <= 1'b0;
            line_err_q  <= 1'b0;
            frame_err_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            phase_q     <= phase_d;
            hi_q        <= hi_d;
            pix_valid_q <= pix_valid_d;
            pix_data_q  <= pix_data_d;
            pix_x_q     <= pix_x_d;
            pix_y_q     <= pix_y_d;
            fs_q        <= fs_d;
            fd_q        <= fd_d;
            line_err_q  <= line_err_d;
            frame_err_q <= frame_err_d;
            ovf_q       <= ovf_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        phase_d     = phase_q;
        hi_d        = hi_q;
        pix_valid_d = pix_valid_q;
        pix_data_d  = pix_data_q;
        pix_x_d     = pix_x_q;
        pix_y_d     = pix_y_q;
        fs_d        = 1'b0;
        fd_d        = 1'b0;
        line_err_d  = line_err_q;
        frame_err_d = frame_err_q;
        ovf_d       = ovf_q;

        // Clear first so an error detected in the same cycle still sets.
        if (err_clr_i) begin
            line_err_d  = 1'b0;
            frame_err_d = 1'b0;
            ovf_d       = 1'b0;
        end

        if (pix_valid_q && pix_ready_i) pix_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (setup_done_i) state_d = WAIT_FRAME;
            end
            WAIT_FRAME: begin
                if (vsync_fall && capture_en_i) begin
                    state_d = ACTIVE;
                    fs_d    = 1'b1;
                    x_d     = '0;
                    y_d     = '0;
                    phase_d = 1'b0;
                end
            end
            ACTIVE: begin
                if (pclk_rise && href_s) begin
                    if (!phase_q) begin
                        hi_d    = data_s;
                        phase_d = 1'b1;
                    end else begin
                        // A new pixel always loads; an accept in the same
                        // cycle means nothing was lost.
                        pix_valid_d = 1'b1;
                        pix_data_d  = {hi_q, data_s};
                        pix_x_d     = x_q;
                        pix_y_d     = y_q;
                        if (pix_valid_q && !pix_ready_i) ovf_d = 1'b1;
                        if (x_q != X_MAX) x_d = x_q + 1'b1;
                        phase_d = 1'b0;
                    end
                end
                if (href_fall) begin
                    if (x_q != X_EXP || phase_q) line_err_d = 1'b1;
                    x_d     = '0;
                    phase_d = 1'b0;
                    if (y_q != Y_MAX) y_d = y_q + 1'b1;
                end
                if (vsync_rise) begin
                    fd_d    = 1'b1;
                    if (y_q != Y_EXP) frame_err_d = 1'b1;
                    state_d = WAIT_FRAME;
                end
            end
            default: state_d = IDLE;
        endcase

        // Losing setup aborts whatever is in flight; sticky flags survive.
        if (!setup_done_i) begin
            state_d = IDLE;
            x_d     = '0;
            y_d     = '0;
            phase_d = 1'b0;
        end
    end

    assign pix_valid_o   = pix_valid_q;
    assign pix_data_o    = pix_data_q;
    assign pix_x_o       = pix_x_q;
    assign pix_y_o       = pix_y_q;
    assign frame_start_o = fs_q;
    assign frame_done_o  = fd_q;
    assign line_err_o    = line_err_q;
    assign frame_err_o   = frame_err_q;
    assign overflow_o    = ovf_q;
endmodule

// File: tb/tb_cam_pixel_capture.sv
module tb_cam_pixel_capture;
    localparam int H   = 4;
    localparam int V   = 2;
    localparam int XW  = 10;
    localparam int YW  = 9;

    typedef struct packed {
        logic [YW-1:0] y;
        logic [XW-1:0] x;
        logic [15:0]   d;
    } pix_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          setup_done = 1'b0;
    logic          capture_en = 1'b1;
    logic          cam_pclk = 1'b0;
    logic          cam_vsync = 1'b1;
    logic          cam_href = 1'b0;
    logic [7:0]    cam_data = 8'h00;
    logic          pix_ready = 1'b1;
    logic          err_clr = 1'b0;
    logic          pix_valid_o;
    logic [15:0]   pix_data_o;
    logic [XW-1:0] pix_x_o;
    logic [YW-1:0] pix_y_o;
    logic          frame_start_o, frame_done_o;
    logic          line_err_o, frame_err_o, overflow_o;

    int n_chk = 0;
    int n_err = 0;

    pix_t exp_q[$];
    pix_t got_q[$];
    int   fs_cnt = 0;
    int   fd_cnt = 0;

    always #5 clk = ~clk;

    cam_pixel_capture #(
        .H_ACTIVE(H), .V_ACTIVE(V), .X_W(XW), .Y_W(YW), .SYNC_STAGES(2)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_n),
        .setup_done_i  (setup_done),
        .capture_en_i  (capture_en),
        .cam_pclk_i    (cam_pclk),
        .cam_vsync_i   (cam_vsync),
        .cam_href_i    (cam_href),
        .cam_data_i    (cam_data),
        .pix_valid_o   (pix_valid_o),
        .pix_ready_i   (pix_ready),
        .pix_data_o    (pix_data_o),
        .pix_x_o       (pix_x_o),
        .pix_y_o       (pix_y_o),
        .frame_start_o (frame_start_o),
        .frame_done_o  (frame_done_o),
        .line_err_o    (line_err_o),
        .frame_err_o   (frame_err_o),
        .overflow_o    (overflow_o),
        .err_clr_i     (err_clr)
    );

    // Inputs change #1 after posedge, so negedge sees what the next posedge sees.
    always @(negedge clk) begin
        if (pix_valid_o && pix_ready) got_q.push_back({pix_y_o, pix_x_o, pix_data_o});
        if (frame_start_o) fs_cnt++;
        if (frame_done_o)  fd_cnt++;
    end

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One camera PCLK period (8 clk): bus changes while PCLK is low.
    task automatic pclk_cyc(input logic v, input logic h, input logic [7:0] d);
        cam_vsync = v; cam_href = h; cam_data = d; cam_pclk = 1'b0;
        clks(4);
        cam_pclk = 1'b1;
        clks(4);
    endtask

    // Frame of nlines lines; line short_line carries H-1 pixels.
    // Expected pixels are queued when expect_pix is set.
    task automatic drive_frame(input int nlines, input int short_line, input bit expect_pix);
        int npix;
        logic [7:0] hi, lo;
        repeat (3) pclk_cyc(1'b1, 1'b0, 8'h00);
        repeat (2) pclk_cyc(1'b0, 1'b0, 8'h00);
        for (int l = 0; l < nlines; l++) begin
            npix = (l == short_line) ? H - 1 : H;
            for (int p = 0; p < npix; p++) begin
                hi = 8'($urandom);
                lo = 8'($urandom);
                pclk_cyc(1'b0, 1'b1, hi);
                pclk_cyc(1'b0, 1'b1, lo);
                if (expect_pix) exp_q.push_back({YW'(l), XW'(p), hi, lo});
            end
            repeat (2) pclk_cyc(1'b0, 1'b0, 8'h00);
        end
        repeat (2) pclk_cyc(1'b1, 1'b0, 8'h00);
        clks(12);
    endtask

    task automatic test_reset;
        n_chk++;
        if ({pix_valid_o, pix_data_o, pix_x_o, pix_y_o, frame_start_o, frame_done_o,
             line_err_o, frame_err_o, overflow_o} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got valid=%b data=%h x=%0d y=%0d errs=%b%b%b want all 0",
                     pix_valid_o, pix_data_o, pix_x_o, pix_y_o, line_err_o, frame_err_o, overflow_o);
        end
        rst_n = 1'b1;
        clks(4);
    endtask

    task automatic test_setup_gate;
        int f0, d0, g0, e0;
        f0 = fs_cnt; g0 = got_q.size();
        drive_frame(V, -1, 1'b0);
        n_chk++;
        if (fs_cnt - f0 !== 0 || got_q.size() - g0 !== 0 || pix_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL setup_gate: starts=%0d pixels=%0d valid=%b want 0 0 0",
                     fs_cnt - f0, got_q.size() - g0, pix_valid_o);
        end
        setup_done = 1'b1;
        clks(3);
        f0 = fs_cnt; d0 = fd_cnt; g0 = got_q.size(); e0 = exp_q.size();
        drive_frame(V, -1, 1'b1);
        n_chk++;
        if (fs_cnt - f0 !== 1 || fd_cnt - d0 !== 1) begin
            n_err++;
            $display("FAIL setup_frame_pulses: start=%0d done=%0d want 1 1", fs_cnt - f0, fd_cnt - d0);
        end
        n_chk++;
        if (got_q.size() - g0 !== exp_q.size() - e0) begin
            n_err++;
            $display("FAIL setup_pix_count: got %0d want %0d", got_q.size() - g0, exp_q.size() - e0);
        end
        for (int i = 0; i < exp_q.size() - e0 && g0 + i < got_q.size(); i++) begin
            n_chk++;
            if (got_q[g0 + i] !== exp_q[e0 + i]) begin
                n_err++;
                $display("FAIL setup_pix[%0d]: got %h want %h", i, got_q[g0 + i], exp_q[e0 + i]);
            end
        end
        n_chk++;
        if ({line_err_o, frame_err_o, overflow_o} !== 3'b000) begin
            n_err++;
            $display("FAIL setup_flags: got %b%b%b want 000", line_err_o, frame_err_o, overflow_o);
        end
    endtask

    // Random back-pressure, with ready forced every 4th cycle so no pixel
    // can be overwritten (pixels arrive every 16 clk).
    task automatic test_back_to_back;
        int g0, e0, cyc;
        bit done;
        g0 = got_q.size(); e0 = exp_q.size(); cyc = 0; done = 1'b0;
        fork
            begin drive_frame(V, -1, 1'b1); done = 1'b1; end
            begin
                while (!done) begin
                    pix_ready = 1'($urandom) | (cyc % 4 == 0);
                    cyc++;
                    clks(1);
                end
                pix_ready = 1'b1;
            end
        join
        clks(2);
        n_chk++;
        if (got_q.size() - g0 !== exp_q.size() - e0) begin
            n_err++;
            $display("FAIL bp_pix_count: got %0d want %0d", got_q.size() - g0, exp_q.size() - e0);
        end
        for (int i = 0; i < exp_q.size() - e0 && g0 + i < got_q.size(); i++) begin
            n_chk++;
            if (got_q[g0 + i] !== exp_q[e0 + i]) begin
                n_err++;
                $display("FAIL bp_pix[%0d]: got %h want %h", i, got_q[g0 + i], exp_q[e0 + i]);
            end
        end
        n_chk++;
        if (overflow_o !== 1'b0) begin
            n_err++;
            $display("FAIL bp_overflow: got %b want 0", overflow_o);
        end
    endtask

    task automatic test_geometry;
        drive_frame(V, 1, 1'b1);
        n_chk++;
        if (line_err_o !== 1'b1 || frame_err_o !== 1'b0) begin
            n_err++;
            $display("FAIL short_line: line_err=%b frame_err=%b want 1 0", line_err_o, frame_err_o);
        end
        drive_frame(V + 1, -1, 1'b1);
        n_chk++;
        if (frame_err_o !== 1'b1) begin
            n_err++;
            $display("FAIL extra_line: frame_err=%b want 1", frame_err_o);
        end
        err_clr = 1'b1;
        clks(1);
        err_clr = 1'b0;
        clks(1);
        n_chk++;
        if ({line_err_o, frame_err_o} !== 2'b00) begin
            n_err++;
            $display("FAIL err_clr: got %b%b want 00", line_err_o, frame_err_o);
        end
    endtask

    task automatic test_overflow;
        int g0;
        pix_t last;
        pix_ready = 1'b0;
        clks(1);
        drive_frame(V, -1, 1'b1);
        last = exp_q[$];
        n_chk++;
        if (overflow_o !== 1'b1 || pix_valid_o !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_flag: overflow=%b valid=%b want 1 1", overflow_o, pix_valid_o);
        end
        n_chk++;
        if ({pix_y_o, pix_x_o, pix_data_o} !== last) begin
            n_err++;
            $display("FAIL ovf_hold: got %h want %h", {pix_y_o, pix_x_o, pix_data_o}, last);
        end
        g0 = got_q.size();
        pix_ready = 1'b1;
        clks(1);
        pix_ready = 1'b0;
        clks(1);
        n_chk++;
        if (pix_valid_o !== 1'b0 || got_q.size() - g0 !== 1) begin
            n_err++;
            $display("FAIL ovf_accept: valid=%b accepted=%0d want 0 1", pix_valid_o, got_q.size() - g0);
        end
        pix_ready = 1'b1;
        err_clr = 1'b1;
        clks(1);
        err_clr = 1'b0;
        clks(1);
        n_chk++;
        if (overflow_o !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_clr: got %b want 0", overflow_o);
        end
    endtask

    task automatic test_capture_en;
        int f0, d0, g0, e0;
        f0 = fs_cnt; d0 = fd_cnt; g0 = got_q.size(); e0 = exp_q.size();
        fork
            drive_frame(V, -1, 1'b1);
            begin clks(60); capture_en = 1'b0; end
        join
        n_chk++;
        if (fs_cnt - f0 !== 1 || fd_cnt - d0 !== 1 || got_q.size() - g0 !== exp_q.size() - e0) begin
            n_err++;
            $display("FAIL en_drop_frame: start=%0d done=%0d pixels=%0d want 1 1 %0d",
                     fs_cnt - f0, fd_cnt - d0, got_q.size() - g0, exp_q.size() - e0);
        end
        for (int i = 0; i < exp_q.size() - e0 && g0 + i < got_q.size(); i++) begin
            n_chk++;
            if (got_q[g0 + i] !== exp_q[e0 + i]) begin
                n_err++;
                $display("FAIL en_pix[%0d]: got %h want %h", i, got_q[g0 + i], exp_q[e0 + i]);
            end
        end
        f0 = fs_cnt; g0 = got_q.size();
        drive_frame(V, -1, 1'b0);
        n_chk++;
        if (fs_cnt - f0 !== 0 || got_q.size() - g0 !== 0) begin
            n_err++;
            $display("FAIL en_off_frame: start=%0d pixels=%0d want 0 0", fs_cnt - f0, got_q.size() - g0);
        end
        capture_en = 1'b1;
    endtask

    task automatic test_reset_midline;
        int f0, d0, g0, e0;
        fork
            drive_frame(V, -1, 1'b0);
            begin
                clks(50);
                rst_n = 1'b0;
                #1;
                n_chk++;
                if ({pix_valid_o, pix_data_o, pix_x_o, pix_y_o, frame_start_o, frame_done_o,
                     line_err_o, frame_err_o, overflow_o} !== '0) begin
                    n_err++;
                    $display("FAIL midline_reset: valid=%b data=%h x=%0d y=%0d want all 0",
                             pix_valid_o, pix_data_o, pix_x_o, pix_y_o);
                end
                clks(3);
                rst_n = 1'b1;
                f0 = fs_cnt; d0 = fd_cnt; g0 = got_q.size();
            end
        join
        n_chk++;
        if (fs_cnt - f0 !== 0 || fd_cnt - d0 !== 0 || got_q.size() - g0 !== 0) begin
            n_err++;
            $display("FAIL after_reset_rest: start=%0d done=%0d pixels=%0d want 0 0 0",
                     fs_cnt - f0, fd_cnt - d0, got_q.size() - g0);
        end
        f0 = fs_cnt; g0 = got_q.size(); e0 = exp_q.size();
        drive_frame(V, -1, 1'b1);
        n_chk++;
        if (fs_cnt - f0 !== 1 || got_q.size() - g0 !== exp_q.size() - e0) begin
            n_err++;
            $display("FAIL resume: start=%0d pixels=%0d want 1 %0d",
                     fs_cnt - f0, got_q.size() - g0, exp_q.size() - e0);
        end
        for (int i = 0; i < exp_q.size() - e0 && g0 + i < got_q.size(); i++) begin
            n_chk++;
            if (got_q[g0 + i] !== exp_q[e0 + i]) begin
                n_err++;
                $display("FAIL resume_pix[%0d]: got %h want %h", i, got_q[g0 + i], exp_q[e0 + i]);
            end
        end
    endtask

    initial begin
        clks(3);
        test_reset();
        test_setup_gate();
        test_back_to_back();
        test_geometry();
        test_overflow();
        test_capture_en();
        test_reset_midline();
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/cam_pixel_capture.md
Name: cam_pixel_capture

Overview:
- Downstream neighbour of the OV7670 SCCB setup stage.
- Held idle until the setup stage raises its done flag. After that, samples the camera parallel bus (PCLK/VSYNC/HREF/D[7:0]) in the system clock domain.
- Assembles byte pairs into RGB565 pixels with x/y coordinates. Presents them on a valid/ready stream to the frame-buffer writer.
- Checks frame geometry. Raises sticky error flags on line-length, line-count and overflow faults.

Parameters:
H_ACTIVE, 640, pixels per line (RGB565, 2 bytes each)
V_ACTIVE, 480, lines per frame
X_W, 10, width of x coordinate
Y_W, 9, width of y coordinate
SYNC_STAGES, 2, synchronizer depth for all camera inputs (min 2)

Ports:
clk_i  in  1  main clock (50 MHz; camera PCLK ≤ clk_i/4)
rst_i  in  1  asynchronous reset, active-low (0 = reset)
setup_done_i  in  1  camera register setup complete
capture_en_i  in  1  1 = capture frames; sampled only at frame start
cam_pclk_i  in  1  camera pixel clock (asynchronous)
cam_vsync_i  in  1  camera VSYNC, high = vertical blanking
cam_href_i  in  1  camera HREF, high = active line bytes
cam_data_i  in  8  camera data bus
pix_valid_o  out  1  pixel available
pix_ready_i  in  1  consumer accepts pixel when valid&ready
pix_data_o  out  16  RGB565; first byte of pair = [15:8]
pix_x_o  out  X_W  column of pixel
pix_y_o  out  Y_W  row of pixel
frame_start_o  out  1  1-cycle pulse at frame start
frame_done_o  out  1  1-cycle pulse at frame end
line_err_o  out  1  sticky: line length ≠ H_ACTIVE
frame_err_o  out  1  sticky: line count ≠ V_ACTIVE
overflow_o  out  1  sticky: pixel overwritten before accept
err_clr_i  in  1  synchronous clear of the three sticky flags

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0; byte_phase 0.
- Synchronization: SYNC_STAGES flops on pclk, vsync, href and data; all synchronized together so they stay aligned.
- Edge detection: one extra register per signal. Produces pclk_rise, vsync_rise, vsync_fall and href_fall.
- Pixel events: href and data are taken on the cycle of pclk_rise.
- State IDLE: wait for setup_done_i=1, then go to WAIT_FRAME. If setup_done_i drops in any state, return to IDLE next cycle and clear counters; sticky flags are kept.
- State WAIT_FRAME: on vsync_fall with capture_en_i=1:
  - Go to ACTIVE.
  - Pulse frame_start_o.
  - Set x=0, y=0, byte_phase=0.
  - With capture_en_i=0, stay.
- State ACTIVE:
  - pclk_rise with href=1, byte_phase=0: latch byte into high half; byte_phase←1.
  - pclk_rise with href=1, byte_phase=1: form {hi, byte} and present it next cycle with the current x, y. Then x←x+1 (saturate at 2^X_W−1) and byte_phase←0.
  - href_fall: if x≠H_ACTIVE or byte_phase=1, set line_err_o. Then x←0, byte_phase←0, y←y+1 (saturate).
  - vsync_rise: pulse frame_done_o. If y≠V_ACTIVE, set frame_err_o. Go to WAIT_FRAME.
  - capture_en_i changes mid-frame: ignored; the frame completes.
- Output register, one deep:
  - pix_valid_o stays high until pix_valid_o&pix_ready_i.
  - If a new pixel completes while valid=1 and ready=0 on that cycle: overwrite data/x/y, keep valid=1, set overflow_o.
  - Simultaneous accept and new pixel: no overflow; the new pixel is loaded.
- Latency: pixel appears SYNC_STAGES+2 clk cycles after the PCLK edge carrying its second byte.
- err_clr_i: clears all sticky flags. An error event in the same cycle wins and the flag stays 1.

Decomposition:
- Shared package cam_pkg:
  - RGB565 width constant (16).
  - Default H_ACTIVE/V_ACTIVE.
  - State encoding localparams IDLE=0, WAIT_FRAME=1, ACTIVE=2.
- Sub-module cam_input_sync: parameterized synchronizer plus edge detector. Outputs synced bus and rise/fall strobes.

Test Plan:
1. setup_done_i=0, drive full camera frame → no frame_start_o, pix_valid_o stays 0. Raise setup_done_i, drive next frame → frame_start_o pulse on VSYNC fall.
2. H_ACTIVE=4, V_ACTIVE=2, pix_ready_i=1, bytes 0x12,0x34,0x56,0x78… → pixels 0x1234 (x0,y0), 0x5678 (x1,y0) … 8 pixels total, frame_done_o pulse, no error flags.
3. One line with 3 pixels instead of 4 → line_err_o=1 after HREF fall. Drive 3 lines → frame_err_o=1. Pulse err_clr_i → both flags 0.
4. pix_ready_i=0 across two completed pixels → overflow_o=1, pix_data_o holds second pixel. Ready=1 for one cycle → accepted, valid=0.
5. capture_en_i dropped mid-frame → frame completes with all pixels and frame_done_o. Next VSYNC fall → no frame_start_o.
6. Assert rst_i=0 mid-line → all outputs 0 immediately. Release reset → capture resumes only after next VSYNC fall.
